// File: rtl/audio_playback_ctrl_pkg.sv
// audio_playback_ctrl_pkg: shared state type and sample width for the playback controller
package audio_playback_ctrl_pkg;
  localparam int SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WAIT_TICK} play_state_t;
endpackage

// File: rtl/audio_playback_ctrl_sigma_delta_dac.sv
// audio_playback_ctrl_sigma_delta_dac: first-order sigma-delta modulator for signed PCM
module audio_playback_ctrl_sigma_delta_dac
  import audio_playback_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                bit_o
);
  logic [SAMPLE_W-1:0] acc_q;
  logic [SAMPLE_W:0]   acc_d;
  // flipping the sign bit turns two's complement into offset binary
  always_comb acc_d = {1'b0, acc_q} + {1'b0, ~sample_i[SAMPLE_W-1], sample_i[SAMPLE_W-2:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      bit_o <= 1'b0;
    end else begin
      acc_q <= acc_d[SAMPLE_W-1:0];
      bit_o <= acc_d[SAMPLE_W];
    end
  end
endmodule

// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: steps through a sample ROM once per tick and drives a sigma-delta pin
module audio_playback_ctrl
  import audio_playback_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 1134,
  parameter int SAMPLE_COUNT = 65536,
  parameter int ADDR_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                src_sel_i,
  input  logic                loop_en_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [SAMPLE_W-1:0] rom_rd_plain_i,
  input  logic [SAMPLE_W-1:0] rom_rd_rev_i,
  output logic                busy_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  output logic                done_o,
  output logic                audio_out_o
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SAMPLE_COUNT - 1);

  if (SAMPLE_COUNT > 2**ADDR_W) begin : g_bad_count
    $error("SAMPLE_COUNT does not fit in ADDR_W");
  end

  play_state_t         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                src_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                done_q;

  // the tick counter free-runs from the FETCH cycle so the sample period is exactly CLK_DIV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      src_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (stop_i) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        idx_q    <= '0;
        sample_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (start_i) begin
              state_q <= FETCH;
              src_q   <= src_sel_i;
            end
          end
          FETCH: state_q <= CAPTURE;
          CAPTURE: begin
            state_q  <= WAIT_TICK;
            sample_q <= src_q ? rom_rd_rev_i : rom_rd_plain_i;
            valid_q  <= 1'b1;
          end
          WAIT_TICK: if (cnt_q == CNT_LAST) begin
            if (idx_q != IDX_LAST) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end else if (loop_en_i) begin
              idx_q   <= '0;
              state_q <= FETCH;
            end else begin
              idx_q    <= '0;
              sample_q <= '0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_addr_o     = idx_q;
  assign busy_o         = state_q != IDLE;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign done_o         = done_q;

  audio_playback_ctrl_sigma_delta_dac u_dac (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (sample_q),
    .bit_o    (audio_out_o)
  );
endmodule
